// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM states, requester id,
// latched transaction and the word-index width helper.
package dmem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

  typedef struct packed {
    req_id_t owner;
    logic    write;
  } txn_t;

  // Word-index width for a memory of 'depth' words; at least one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshake plus memory-side bus of the data-memory arbiter.
// slave = arbiter view, master = requesters/memory view.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [DATA_W-1:0]              resp_rdata;
  logic                           resp_err;
  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_wdata;
  logic                           mem_read;
  logic                           mem_write;
  logic [DATA_W-1:0]              mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the
// pointer, and each granted accept hands priority to the other port.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output req_id_t    ptr
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr[0] ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (advance && |grant)
      ptr <= req_id_t'(!grant[1]);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer in front of the single-port data memory:
// IDLE accepts, ACCESS fires one strobe, RESP returns the registered read data.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic          busy
);

  localparam int IDX_W = idx_width(DEPTH);

  state_e             state;
  txn_t               txn_q;
  logic [1:0]         grant;
  req_id_t            rr_ptr;
  req_id_t            win_id;
  logic               accept;
  logic [NUM_REQ-1:0] addr_bad;

  // Misaligned or beyond the memory: answered with an error, never strobed.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
    assign addr_bad[i] = (bus.req_addr[i][1:0] != 2'b00) ||
                         ((bus.req_addr[i] >> (IDX_W + 2)) != '0);
  end

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .valid   (bus.req_valid),
    .advance (accept),
    .grant   (grant),
    .ptr     (rr_ptr)
  );

  assign bus.req_ready = (state == IDLE) ? grant : 2'b00;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign win_id        = req_id_t'(grant[1]);
  assign busy          = (state != IDLE);

  // Memory read data is registered, so it lines up with the RESP cycle.
  assign bus.resp_rdata = (|bus.resp_valid && !txn_q.write && !bus.resp_err) ?
                          bus.mem_rdata : {DATA_W{1'b0}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      txn_q          <= '0;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_valid <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_valid <= '0;
      bus.resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            txn_q.owner <= win_id;
            txn_q.write <= bus.req_write[win_id];
            if (addr_bad[win_id]) begin
              state                  <= RESP;
              bus.resp_valid[win_id] <= 1'b1;
              bus.resp_err           <= 1'b1;
            end else begin
              state         <= ACCESS;
              bus.mem_read  <= !bus.req_write[win_id];
              bus.mem_write <= bus.req_write[win_id];
              bus.mem_addr  <= ADDR_W'(bus.req_addr[win_id][IDX_W+1:2]);
              bus.mem_wdata <= bus.req_write[win_id] ? bus.req_wdata[win_id] : '0;
            end
          end
        end
        ACCESS: begin
          state                       <= RESP;
          bus.resp_valid[txn_q.owner] <= 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.req_ready));
  a_one_strobe: assert property (@(posedge clk) disable iff (rst)
    !(bus.mem_read && bus.mem_write));
  a_tie_to_ptr: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE && &bus.req_valid) |-> grant[rr_ptr]);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus random bench for dmem_arbiter against a transaction-level model
// (round-robin winner, fixed latencies, shadow memory).
module tb_dmem_arbiter;

  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int AW     = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic mem_init;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc ();

  dmem_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifc.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Memory with registered read data, not affected by the arbiter reset.
  logic [DATA_W-1:0] ram [DEPTH];

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 + 32'(i * 17);
  endfunction

  always @(posedge clk) begin
    if (mem_init)
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    else if (ifc.mem_write)
      ram[ifc.mem_addr[AW-1:0]] <= ifc.mem_wdata;
    ifc.mem_rdata <= ifc.mem_read ? ram[ifc.mem_addr[AW-1:0]] : '0;
  end

  // Reference model
  logic [31:0] ref_mem [DEPTH];
  int          ptr, idle_at, acc_cyc, resp_cyc, r_owner, a_idx;
  logic        a_wr, r_err;
  logic [31:0] a_data, r_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick();
    logic [1:0] v;
    v = ifc.req_valid;
    if (v == 2'b11) return ptr;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    ptr = 0; idle_at = cyc; acc_cyc = -1; resp_cyc = -1;
  endtask

  // Check one cycle against the model, then advance to the next negedge.
  task automatic tick(output int acc);
    int          w;
    logic [1:0]  exp_rdy, exp_rv;
    logic        strobe;
    logic [31:0] a;
    #1;
    acc = -1; w = -1; exp_rdy = '0; exp_rv = '0;
    if (cyc >= idle_at) begin
      w = pick();
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    strobe = (cyc == acc_cyc);
    if (cyc == resp_cyc) exp_rv[r_owner] = 1'b1;
    chk("req_ready", 64'(ifc.req_ready), 64'(exp_rdy));
    chk("busy", 64'(busy), 64'(cyc < idle_at));
    chk("resp_valid", 64'(ifc.resp_valid), 64'(exp_rv));
    if (cyc == resp_cyc) begin
      chk("resp_err", 64'(ifc.resp_err), 64'(r_err));
      chk("resp_rdata", 64'(ifc.resp_rdata), 64'(r_data));
    end
    chk("mem_read", 64'(ifc.mem_read), 64'(strobe && !a_wr));
    chk("mem_write", 64'(ifc.mem_write), 64'(strobe && a_wr));
    chk("mem_wdata", 64'(ifc.mem_wdata), (strobe && a_wr) ? 64'(a_data) : 64'(0));
    if (strobe) begin
      chk("mem_addr", 64'(ifc.mem_addr), 64'(a_idx));
      if (a_wr) ref_mem[a_idx] = a_data;
    end
    if (w >= 0) begin
      acc = w; ptr = 1 - w; r_owner = w;
      a = ifc.req_addr[w];
      a_wr = ifc.req_write[w];
      if (a[1:0] != 2'b00 || a >= 32'(DEPTH * 4)) begin
        r_err = 1'b1; r_data = '0; acc_cyc = -1;
        resp_cyc = cyc + 1; idle_at = cyc + 2;
      end else begin
        a_idx = int'(a >> 2); a_data = ifc.req_wdata[w];
        r_err = 1'b0; r_data = a_wr ? 32'h0 : ref_mem[a_idx];
        acc_cyc = cyc + 1; resp_cyc = cyc + 2; idle_at = cyc + 3;
      end
    end
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic idle(input int n);
    int acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic set_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    ifc.req_valid[p] = 1'b1; ifc.req_write[p] = w;
    ifc.req_addr[p]  = a;    ifc.req_wdata[p] = d;
  endtask

  // Tick until port p (or any port if p < 0) is accepted, bounded.
  task automatic wait_acc(input int p, output int id);
    int acc;
    bit got;
    got = 0; id = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(acc);
      if (acc >= 0 && (p < 0 || acc == p)) begin got = 1; id = acc; end
    end
    chk("accept_timeout", 64'(got), 64'(1));
  endtask

  task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    int id;
    set_req(p, w, a, d);
    wait_acc(p, id);
    ifc.req_valid[p] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_mem_read", 64'(ifc.mem_read), 64'(0));
    chk("rst_mem_write", 64'(ifc.mem_write), 64'(0));
    chk("rst_resp_valid", 64'(ifc.resp_valid), 64'(0));
    model_reset();
    @(posedge clk); cyc++; @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(9);
    if (r < 7)       a = 32'($urandom_range(DEPTH - 1)) << 2;
    else if (r == 7) a = (32'($urandom_range(DEPTH - 1)) << 2) | 32'($urandom_range(3, 1));
    else             a = ($urandom() & ~32'h3) | 32'(DEPTH * 4);
    return a;
  endfunction

  initial begin
    int id, acc;
    rst = 1'b1; mem_init = 1'b1;
    ifc.req_valid = '0; ifc.req_write = '0; ifc.req_addr = '0; ifc.req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    @(posedge clk); @(negedge clk);
    mem_init = 1'b0;
    chk("rst_ready", 64'(ifc.req_ready), 64'(0));
    do_reset();

    // Store then load through port 0.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF);
    issue(0, 1'b0, 32'h10, 32'h0);
    idle(4);

    // Both ports held valid from reset: grants alternate starting at port 0.
    do_reset();
    set_req(0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 32'h4, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_acc(-1, id);
      chk("rr_order", 64'(id), 64'(k % 2));
    end
    ifc.req_valid = '0;
    idle(4);

    // Bad addresses on port 1: misaligned, then out of range.
    issue(1, 1'b0, 32'h82, 32'h0);
    issue(1, 1'b0, 32'h100, 32'h0);
    idle(3);

    // Reset during the ACCESS cycle of a store: nothing committed.
    set_req(0, 1'b1, 32'h7C, 32'h12345678);
    wait_acc(0, id);
    ifc.req_valid[0] = 1'b0;
    chk("abort_pre_write", 64'(ifc.mem_write), 64'(1));
    do_reset();
    idle(2);
    issue(0, 1'b0, 32'h7C, 32'h0);
    idle(4);

    // Port 0 gives up while port 1 is being served.
    issue(1, 1'b0, 32'h20, 32'h0);
    set_req(0, 1'b0, 32'h40, 32'h0);
    tick(acc);
    ifc.req_valid[0] = 1'b0;
    idle(5);
    set_req(0, 1'b0, 32'h8, 32'h0);
    set_req(1, 1'b0, 32'hC, 32'h0);
    wait_acc(-1, id);
    chk("ptr_after_drop", 64'(id), 64'(0));
    ifc.req_valid = '0;
    idle(4);

    // Random traffic from both ports.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!ifc.req_valid[p]) begin
          if ($urandom_range(2) == 0)
            set_req(p, 1'($urandom_range(1)), rand_addr(), $urandom());
        end else if ($urandom_range(15) == 0) begin
          ifc.req_valid[p] = 1'b0;
        end
      end
      tick(acc);
      if (acc >= 0) ifc.req_valid[acc] = 1'b0;
    end
    ifc.req_valid = '0;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
